fp_divider_seq: RTL and testbench
=================================

FP_DIVIDER_SEQ -- requirements
Module: fp_divider_seq

Interface
REQ-001 Parameters: none; all widths and constants SHALL come from the shared package. The package holds BIAS=127, EXP_W=8, MANT_W=23 and QNAN=0x7FC00000.
REQ-002 CLK  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  operation request, sampled each cycle.
REQ-005 Sx,Sy  input  1  dividend and divisor signs.
REQ-006 Ex,Ey  input  8  biased exponents.
REQ-007 Mx,My  input  23  fraction fields, hidden bit excluded.
REQ-008 R_mode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 Sz, Ez[7:0], Mz[22:0]  output  quotient fields.
REQ-012 invalid_flag, divzero_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag  output  1 each  exception flags.

Function
REQ-013 A start sampled while busy=0 SHALL be accepted and SHALL latch all operand inputs and R_mode. This is cycle 0.
REQ-014 A start sampled while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-015 States SHALL be IDLE, CHECK, DIVIDE, ROUND and DONE.
REQ-016 State transitions:
- IDLE->CHECK on accepted start.
- CHECK->DONE for special operands.
- CHECK->DIVIDE otherwise.
- DIVIDE->ROUND when the iteration counter reaches 25.
- ROUND->DONE.
- DONE->IDLE.
REQ-017 busy SHALL be high from cycle 1 through the DONE cycle inclusive.
REQ-018 done SHALL be high only in the DONE cycle: cycle 2 for special operands, cycle 28 for normal operands.
REQ-019 Sz, Ez, Mz and all flags SHALL update in the DONE cycle and hold until the next accepted start or reset.
REQ-020 Subnormal inputs (E=0) SHALL be treated as zero.
REQ-021 Operand classification in CHECK:
- NaN/x, x/NaN, 0/0 and inf/inf SHALL give QNAN with invalid_flag=1.
- Finite nonzero/0 SHALL give ±inf with divzero_flag=1.
- inf/finite SHALL give ±inf.
- finite/inf and 0/finite-nonzero SHALL give ±0 with zero_flag=1.
REQ-022 Sz SHALL equal Sx XOR Sy for every non-NaN result.
REQ-023 DIVIDE SHALL run a restoring division of {1,Mx} by {1,My}, one quotient bit per cycle for 26 cycles, giving q[25:0] and a final remainder.
REQ-024 The working exponent SHALL be the 10-bit signed value Ex - Ey + BIAS.
REQ-025 Normalization when q[25]=1:
- mantissa = q[25:2]
- round bit = q[1]
- sticky = q[0] OR (remainder != 0)
REQ-026 Normalization when q[25]=0:
- mantissa = q[24:1]
- round bit = q[0]
- sticky = (remainder != 0)
- exponent decremented by 1
REQ-027 Rounding SHALL follow R_mode per IEEE-754. inexact_flag SHALL equal round OR sticky.
REQ-028 A rounding carry-out SHALL set the mantissa to 1.0 and increment the exponent.
REQ-029 An exponent >= 255 after rounding SHALL set overflow_flag=1 and inexact_flag=1. The result SHALL be:
- RNE: ±inf.
- RTZ: ±0x7F7FFFFF (max finite).
- Directed modes: inf toward the mode's direction, max finite away from it.
REQ-030 An exponent <= 0 after rounding SHALL flush the result to ±0 and set underflow_flag=1, inexact_flag=1 and zero_flag=1.

Reset
REQ-031 RST=1 at any edge, including mid-operation, SHALL force IDLE and clear the iteration counter.
REQ-032 RST=1 SHALL drive busy, done, Sz, Ez, Mz and all flags to 0. The aborted operation SHALL produce no done.

Structure
REQ-033 The shared package fp_pkg SHALL hold BIAS, EXP_W, MANT_W, QNAN, the R_mode encodings and the state enumeration.
REQ-034 Rounding and overflow/underflow resolution SHALL be the single combinational sub-module fp_div_round. Its inputs are mantissa, round, sticky, sign, exponent and R_mode.

Verification
REQ-035 Normal divide: 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000, done at cycle 28, all flags 0.
REQ-036 Rounding modes on 0x3F800000 / 0x40400000 (1.0/3.0):
- RNE -> 0x3EAAAAAB, inexact_flag=1.
- RTZ -> 0x3EAAAAAA, inexact_flag=1.
REQ-037 Special operands, both with done at cycle 2:
- 0x3F800000 / 0x00000000 -> 0x7F800000, divzero_flag=1.
- 0x00000000 / 0x00000000 -> 0x7FC00000, invalid_flag=1.
REQ-038 Overflow on 0x7F000000 / 0x00800000:
- RNE -> 0x7F800000, overflow_flag=1, inexact_flag=1.
- RTZ -> 0x7F7FFFFF.
REQ-039 Underflow: 0x00800000 / 0x40000000 -> 0x00000000 with underflow_flag=1, inexact_flag=1 and zero_flag=1.
REQ-040 Control scenario:
- A second start at cycle 5 SHALL be ignored.
- RST at cycle 10 SHALL give busy=0, all outputs 0 and no done.
- A subsequent 6.0/2.0 SHALL complete correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, rounding-mode encodings and FSM states for the
// sequential single-precision divider.
package fp_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Quotient bit index at which DIVIDE hands over to ROUND
  localparam int ITER_LAST = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_e;

endpackage

// File: rtl/fp_div_round.sv
// Combinational rounding plus overflow/underflow resolution for the divider.
// Takes the normalized 23-bit fraction (hidden bit implied) and a signed exponent.
module fp_div_round
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  input  logic              round_i,
  input  logic              sticky_i,
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [1:0]        rmode_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              inexact_o,
  output logic              zero_o
);

  logic              lost;
  logic              inc;
  logic [MANT_W:0]   frac_inc;
  logic              carry;
  logic signed [9:0] exp_r;
  logic              inf_sel;

  always_comb begin
    lost = round_i | sticky_i;
    case (rmode_i)
      RM_RNE:  inc = round_i & (sticky_i | mant_i[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = lost & ~sign_i;
      default: inc = lost & sign_i;
    endcase

    // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0
    frac_inc = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc};
    carry    = frac_inc[MANT_W];
    exp_r    = exp_i + $signed({9'd0, carry});

    inf_sel = (rmode_i == RM_RNE) |
              ((rmode_i == RM_RUP) & ~sign_i) |
              ((rmode_i == RM_RDN) & sign_i);

    exp_o       = exp_r[EXP_W-1:0];
    mant_o      = frac_inc[MANT_W-1:0];
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    inexact_o   = lost;
    zero_o      = 1'b0;

    if (exp_r >= 10'sd255) begin
      overflow_o = 1'b1;
      inexact_o  = 1'b1;
      exp_o      = inf_sel ? 8'hFF : 8'hFE;
      mant_o     = inf_sel ? '0 : '1;
    end else if (exp_r <= 10'sd0) begin
      underflow_o = 1'b1;
      inexact_o   = 1'b1;
      zero_o      = 1'b1;
      exp_o       = '0;
      mant_o      = '0;
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential single-precision divider: special-operand check, 26-cycle
// restoring mantissa division, then a single rounding cycle.
module fp_divider_seq
  import fp_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              Sx,
  input  logic              Sy,
  input  logic [EXP_W-1:0]  Ex,
  input  logic [EXP_W-1:0]  Ey,
  input  logic [MANT_W-1:0] Mx,
  input  logic [MANT_W-1:0] My,
  input  logic [1:0]        R_mode,
  output logic              busy,
  output logic              done,
  output logic              Sz,
  output logic [EXP_W-1:0]  Ez,
  output logic [MANT_W-1:0] Mz,
  output logic              invalid_flag,
  output logic              divzero_flag,
  output logic              overflow_flag,
  output logic              underflow_flag,
  output logic              inexact_flag,
  output logic              zero_flag
);

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic              sx_q, sy_q;
  logic [EXP_W-1:0]  ex_q, ey_q;
  logic [MANT_W-1:0] mx_q, my_q;
  logic [1:0]        rm_q;
  logic [24:0]       rem_q, rem_d;
  logic [25:0]       quot_q, quot_d;

  logic              sz_q, sz_d;
  logic [EXP_W-1:0]  ez_q, ez_d;
  logic [MANT_W-1:0] mz_q, mz_d;
  logic inv_q, inv_d, dz_q, dz_d, ov_q, ov_d, un_q, un_d, ix_q, ix_d, zf_q, zf_d;

  logic accept, iterate, load_spec, load_rnd;

  // Operand classification; subnormals count as zero
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, special, sign_q;
  assign x_nan   = (ex_q == '1) && (mx_q != '0);
  assign y_nan   = (ey_q == '1) && (my_q != '0);
  assign x_inf   = (ex_q == '1) && (mx_q == '0);
  assign y_inf   = (ey_q == '1) && (my_q == '0);
  assign x_zero  = (ex_q == '0);
  assign y_zero  = (ey_q == '0);
  assign special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
  assign sign_q  = sx_q ^ sy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (special) state_d = S_DONE;
        else begin
          state_d = S_DIVIDE;
          cnt_d   = 5'd1;
        end
      end
      S_DIVIDE: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_LAST)) state_d = S_ROUND;
      end
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    accept    = (state_q == S_IDLE) && start;
    iterate   = ((state_q == S_CHECK) && !special) || (state_q == S_DIVIDE);
    load_spec = (state_q == S_CHECK) && special;
    load_rnd  = (state_q == S_ROUND);
  end

  // Restoring division: the first quotient bit is produced already in CHECK
  logic [23:0] div_y;
  logic        rem_ge;
  logic [23:0] rem_sub;

  always_comb begin
    div_y   = {1'b1, my_q};
    rem_ge  = (rem_q >= {1'b0, div_y});
    rem_sub = rem_ge ? 24'(rem_q - {1'b0, div_y}) : rem_q[23:0];
    rem_d   = rem_q;
    quot_d  = quot_q;
    if (accept) begin
      rem_d  = {2'b01, Mx};
      quot_d = '0;
    end else if (iterate) begin
      rem_d  = {rem_sub, 1'b0};
      quot_d = {quot_q[24:0], rem_ge};
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      sx_q <= Sx;
      sy_q <= Sy;
      ex_q <= Ex;
      ey_q <= Ey;
      mx_q <= Mx;
      my_q <= My;
      rm_q <= R_mode;
    end
    rem_q  <= rem_d;
    quot_q <= quot_d;
  end

  // Normalization of the quotient ahead of rounding
  logic signed [9:0] exp_w, exp_n;
  logic              q_hi, rnd_n, sticky_n;
  logic [MANT_W-1:0] frac_n;

  always_comb begin
    q_hi     = quot_q[25];
    exp_w    = $signed({2'b00, ex_q}) - $signed({2'b00, ey_q}) + $signed(10'(BIAS));
    exp_n    = q_hi ? exp_w : exp_w - 10'sd1;
    frac_n   = q_hi ? quot_q[24:2] : quot_q[23:1];
    rnd_n    = q_hi ? quot_q[1] : quot_q[0];
    sticky_n = (q_hi & quot_q[0]) | (rem_q != '0);
  end

  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  logic r_ov, r_un, r_ix, r_zero;

  fp_div_round u_round (
    .mant_i      (frac_n),
    .round_i     (rnd_n),
    .sticky_i    (sticky_n),
    .sign_i      (sign_q),
    .exp_i       (exp_n),
    .rmode_i     (rm_q),
    .exp_o       (r_exp),
    .mant_o      (r_mant),
    .overflow_o  (r_ov),
    .underflow_o (r_un),
    .inexact_o   (r_ix),
    .zero_o      (r_zero)
  );

  always_comb begin
    {sz_d, ez_d, mz_d} = {sz_q, ez_q, mz_q};
    {inv_d, dz_d, ov_d, un_d, ix_d, zf_d} = {inv_q, dz_q, ov_q, un_q, ix_q, zf_q};
    if (load_spec) begin
      {inv_d, dz_d, ov_d, un_d, ix_d, zf_d} = '0;
      if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
        {sz_d, ez_d, mz_d} = QNAN;
        inv_d = 1'b1;
      end else if (x_inf || y_zero) begin
        {sz_d, ez_d, mz_d} = {sign_q, 8'hFF, 23'h0};
        dz_d = y_zero & ~x_inf;
      end else begin
        {sz_d, ez_d, mz_d} = {sign_q, 31'h0};
        zf_d = 1'b1;
      end
    end else if (load_rnd) begin
      {sz_d, ez_d, mz_d} = {sign_q, r_exp, r_mant};
      {inv_d, dz_d, ov_d, un_d, ix_d, zf_d} = {2'b00, r_ov, r_un, r_ix, r_zero};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      {sz_q, ez_q, mz_q} <= '0;
      {inv_q, dz_q, ov_q, un_q, ix_q, zf_q} <= '0;
    end else begin
      {sz_q, ez_q, mz_q} <= {sz_d, ez_d, mz_d};
      {inv_q, dz_q, ov_q, un_q, ix_q, zf_q} <= {inv_d, dz_d, ov_d, un_d, ix_d, zf_d};
    end
  end

  assign Sz             = sz_q;
  assign Ez             = ez_q;
  assign Mz             = mz_q;
  assign invalid_flag   = inv_q;
  assign divzero_flag   = dz_q;
  assign overflow_flag  = ov_q;
  assign underflow_flag = un_q;
  assign inexact_flag   = ix_q;
  assign zero_flag      = zf_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Self-checking bench for fp_divider_seq: directed corner cases, control
// scenarios and randomized operands against an integer-arithmetic model.
module tb_fp_divider_seq;

  logic        CLK = 1'b0;
  logic        RST, start, Sx, Sy;
  logic [7:0]  Ex, Ey;
  logic [22:0] Mx, My;
  logic [1:0]  R_mode;
  logic        busy, done, Sz;
  logic [7:0]  Ez;
  logic [22:0] Mz;
  logic        invalid_flag, divzero_flag, overflow_flag;
  logic        underflow_flag, inexact_flag, zero_flag;

  int checks = 0;
  int errors = 0;

  fp_divider_seq dut (
    .CLK(CLK), .RST(RST), .start(start),
    .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My), .R_mode(R_mode),
    .busy(busy), .done(done), .Sz(Sz), .Ez(Ez), .Mz(Mz),
    .invalid_flag(invalid_flag), .divzero_flag(divzero_flag),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .inexact_flag(inexact_flag), .zero_flag(zero_flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res_now();
    return {Sz, Ez, Mz};
  endfunction

  function automatic logic [5:0] flags_now();
    return {invalid_flag, divzero_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag};
  endfunction

  // Reference: {special, flags[5:0], result[31:0]}, flags = {inv,dz,ov,un,ix,zero}
  function automatic logic [38:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] rm);
    logic   s, a_nan, b_nan, a_inf, b_inf, a_z, b_z, rb, st, up, inf_sel;
    int     ea, eb, e;
    longint xa, yb, num, q, r, m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_z = (ea == 0);
    b_z = (eb == 0);
    if (a_nan || b_nan || (a_z && b_z) || (a_inf && b_inf))
      return {1'b1, 6'b100000, 32'h7FC00000};
    if (a_inf) return {1'b1, 6'b000000, s, 8'hFF, 23'h0};
    if (b_z)   return {1'b1, 6'b010000, s, 8'hFF, 23'h0};
    if (b_inf || a_z) return {1'b1, 6'b000001, s, 31'h0};
    xa  = longint'({1'b1, a[22:0]});
    yb  = longint'({1'b1, b[22:0]});
    num = xa * 33554432;
    q   = num / yb;
    r   = num % yb;
    e   = ea - eb + 127;
    if (q >= 33554432) begin
      m = q / 4; rb = q[1]; st = q[0] | (r != 0);
    end else begin
      m = q / 2; rb = q[0]; st = (r != 0); e = e - 1;
    end
    case (rm)
      2'b00:   up = rb & (st | m[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = (rb | st) & ~s;
      default: up = (rb | st) & s;
    endcase
    m = m + longint'(up);
    if (m == 16777216) begin
      m = 8388608; e = e + 1;
    end
    if (e >= 255) begin
      inf_sel = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
      return {1'b0, 6'b001010, s, inf_sel ? 8'hFF : 8'hFE, inf_sel ? 23'h0 : 23'h7FFFFF};
    end
    if (e <= 0) return {1'b0, 6'b000111, s, 31'h0};
    return {1'b0, 4'b0000, rb | st, 1'b0, s, 8'(e), m[22:0]};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    {Sx, Ex, Mx} = a;
    {Sy, Ey, My} = b;
    R_mode = rm;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input logic [31:0] er, input logic [5:0] ef, input int el,
                        input string tag);
    int lat;
    bit seen;
    logic [31:0] held;
    @(negedge CLK);
    drive(a, b, rm);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    lat = 1;
    chk({tag, "_busy1"}, 64'(busy), 64'd1);
    seen = 0;
    while (!seen && lat < 40) begin
      if (done) seen = 1;
      else begin
        @(negedge CLK);
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_latency"}, 64'(lat), 64'(el));
      chk({tag, "_result"}, 64'(res_now()), 64'(er));
      chk({tag, "_flags"}, 64'(flags_now()), 64'(ef));
      chk({tag, "_busy_done"}, 64'(busy), 64'd1);
      held = res_now();
      @(negedge CLK);
      chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
      chk({tag, "_hold"}, 64'(res_now()), 64'(held));
    end
  endtask

  initial begin
    logic [38:0] rf;
    logic [31:0] a, b;
    logic [1:0]  rm;
    int n, dones;
    bit seen;

    RST = 1'b1;
    start = 1'b0;
    drive(32'h0, 32'h0, 2'b00);
    repeat (3) @(negedge CLK);
    chk("reset_ctrl", 64'({busy, done}), 64'd0);
    chk("reset_res", 64'(res_now()), 64'd0);
    chk("reset_flags", 64'(flags_now()), 64'd0);
    RST = 1'b0;

    // Directed cases
    run_op(32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 6'b000000, 28, "six_by_two");
    run_op(32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 6'b000010, 28, "third_rne");
    run_op(32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 6'b000010, 28, "third_rtz");
    run_op(32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 6'b000010, 28, "third_rup");
    run_op(32'hBF800000, 32'h40400000, 2'b11, 32'hBEAAAAAB, 6'b000010, 28, "negthird_rdn");
    run_op(32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 6'b010000, 2, "div_zero");
    run_op(32'h00000000, 32'h00000000, 2'b00, 32'h7FC00000, 6'b100000, 2, "zero_zero");
    run_op(32'h7F800000, 32'h40000000, 2'b00, 32'h7F800000, 6'b000000, 2, "inf_fin");
    run_op(32'h40000000, 32'hFF800000, 2'b00, 32'h80000000, 6'b000001, 2, "fin_inf");
    run_op(32'h7F000000, 32'h00800000, 2'b00, 32'h7F800000, 6'b001010, 28, "ovf_rne");
    run_op(32'h7F000000, 32'h00800000, 2'b01, 32'h7F7FFFFF, 6'b001010, 28, "ovf_rtz");
    run_op(32'h7F000000, 32'h00800000, 2'b11, 32'h7F7FFFFF, 6'b001010, 28, "ovf_rdn_pos");
    run_op(32'hFF000000, 32'h00800000, 2'b11, 32'hFF800000, 6'b001010, 28, "ovf_rdn_neg");
    run_op(32'h00800000, 32'h40000000, 2'b00, 32'h00000000, 6'b000111, 28, "underflow");

    // Start while busy is ignored
    @(negedge CLK);
    drive(32'h40C00000, 32'h40000000, 2'b00);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 1;
    seen = 0;
    while (n < 40 && !seen) begin
      start = (n == 5);
      if (n == 5) drive(32'h3F800000, 32'h40400000, 2'b01);
      if (done) seen = 1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
    start = 1'b0;
    chk("ign_done_seen", 64'(seen), 64'd1);
    chk("ign_latency", 64'(n), 64'd28);
    chk("ign_result", 64'(res_now()), 64'h40400000);
    chk("ign_flags", 64'(flags_now()), 64'd0);
    @(negedge CLK);

    // Reset mid-operation aborts with no done
    @(negedge CLK);
    drive(32'h3F800000, 32'h40400000, 2'b00);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 5);
      if (done) dones++;
      if (c == 10) RST = 1'b1;
      else @(negedge CLK);
    end
    start = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_ctrl", 64'({busy, done}), 64'd0);
    chk("rst_res", 64'(res_now()), 64'd0);
    chk("rst_flags", 64'(flags_now()), 64'd0);
    for (int c = 0; c < 35; c++) begin
      if (done) dones++;
      @(negedge CLK);
    end
    chk("rst_no_done", 64'(dones), 64'd0);
    run_op(32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 6'b000000, 28, "after_rst");

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = $urandom;
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: a[30:23] = 8'($urandom_range(200, 254));
        1: b[30:23] = 8'($urandom_range(200, 254));
        2: a[30:23] = (($urandom_range(0, 1)) != 0) ? 8'hFF : 8'h00;
        3: b[30:23] = (($urandom_range(0, 1)) != 0) ? 8'hFF : 8'h00;
        default: begin
          a[30:23] = 8'($urandom_range(64, 190));
          b[30:23] = 8'($urandom_range(64, 190));
        end
      endcase
      if (a[30:23] == 8'hFF && ($urandom_range(0, 1) != 0)) a[22:0] = '0;
      if (b[30:23] == 8'hFF && ($urandom_range(0, 1) != 0)) b[22:0] = '0;
      rf = ref_div(a, b, rm);
      run_op(a, b, rm, rf[31:0], rf[37:32], rf[38] ? 2 : 28, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
